// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Byte-masked data-memory slave for the load/store unit. A request presented
// with cs low is captured in IDLE, held for WAIT_STATES cycles, and committed
// to the internal word array on the edge that enters RESP. The cycle after
// RESP carries a one-cycle ready pulse, with err and data_rd valid alongside.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words in the array (power of two, >= 2)
//   WAIT_STATES  extra cycles before the response (0..15)
//   BASE_ADDR    word-aligned byte address mapped to word 0
//
// Ports
//   clk      clock, rising edge
//   rst_n    asynchronous active-low reset
//   cs       chip select, active-low request
//   wr       0 = store, 1 = load
//   mask     byte-lane write enables for stores
//   addr     byte address (bits [1:0] ignored)
//   data_wr  lane-positioned store data
//   data_rd  full read word, held until the next load response
//   ready    one-cycle completion pulse
//   err      out-of-range flag, meaningful only with ready
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cs,
    input  logic        wr,
    input  logic [3:0]  mask,
    input  logic [31:0] addr,
    input  logic [31:0] data_wr,
    output logic [31:0] data_rd,
    output logic        ready,
    output logic        err
);

    localparam int          IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN      = 33'(DEPTH_WORDS) << 2;
    localparam bit          ZERO_WAIT = (WAIT_STATES == 0);
    localparam logic [3:0]  WS_INIT   = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t      state_reg;
    logic [3:0]  cnt_reg;
    logic        wr_reg;
    logic [3:0]  mask_reg;
    logic [31:0] addr_reg;
    logic [31:0] data_wr_reg;
    logic        oor_reg;
    logic [31:0] rd_word_reg;

    logic [31:0] mem [DEPTH_WORDS];

    logic             accept;
    logic             enter_resp;
    logic             c_wr;
    logic [3:0]       c_mask;
    logic [31:0]      c_addr;
    logic [31:0]      c_data;
    logic [31:0]      offset;
    logic             in_range;
    logic [IDX_W-1:0] idx;
    logic             mem_we;

    // With zero wait states the commit happens on the accept edge itself, so
    // the live request fields are used; otherwise the captured copy is used.
    always_comb begin
        accept     = (state_reg == ST_IDLE) && !cs;
        enter_resp = (accept && ZERO_WAIT) ||
                     ((state_reg == ST_WAIT) && (cnt_reg == 4'd1));
        if (state_reg == ST_IDLE) begin
            c_wr   = wr;
            c_mask = mask;
            c_addr = addr;
            c_data = data_wr;
        end else begin
            c_wr   = wr_reg;
            c_mask = mask_reg;
            c_addr = addr_reg;
            c_data = data_wr_reg;
        end
        // Unsigned subtraction: addresses below the base wrap high and fail
        // the range test.
        offset   = c_addr - BASE_ADDR;
        in_range = ({1'b0, offset} < SPAN);
        idx      = offset[IDX_W+1:2];
        // Gating with rst_n keeps the array untouched while reset is held.
        mem_we   = rst_n && enter_resp && !c_wr && in_range;
    end

    // Array with per-byte write enables and a registered read port; no reset
    // so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (c_mask[i]) begin
                    mem[idx][8*i +: 8] <= c_data[8*i +: 8];
                end
            end
        end
        if (enter_resp) begin
            rd_word_reg <= mem[idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= 4'd0;
            wr_reg      <= 1'b0;
            mask_reg    <= 4'd0;
            addr_reg    <= 32'd0;
            data_wr_reg <= 32'd0;
            oor_reg     <= 1'b0;
            ready       <= 1'b0;
            err         <= 1'b0;
            data_rd     <= 32'd0;
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            if (enter_resp) begin
                oor_reg <= !in_range;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (!cs) begin
                        wr_reg      <= wr;
                        mask_reg    <= mask;
                        addr_reg    <= addr;
                        data_wr_reg <= data_wr;
                        cnt_reg     <= WS_INIT;
                        state_reg   <= ZERO_WAIT ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt_reg <= cnt_reg - 4'd1;
                    if (cnt_reg == 4'd1) begin
                        state_reg <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    // cs is deliberately not looked at here; the next accept
                    // can only happen from IDLE.
                    state_reg <= ST_IDLE;
                    ready     <= 1'b1;
                    err       <= oor_reg;
                    if (wr_reg) begin
                        data_rd <= oor_reg ? 32'd0 : rd_word_reg;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Two responders share clk/rst_n: instance 0 with one wait state and a 1024
// word array at base 0, instance 1 with zero wait states and a 64 word array
// at base 0x100. A word-level model (associative array plus the expected
// ready cycle of the request in flight) predicts ready/err/data_rd every
// cycle; directed accesses also compare against literal values.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int          WS0 = 1;
    localparam int          WS1 = 0;
    localparam int          D0  = 1024;
    localparam int          D1  = 64;
    localparam logic [31:0] B0  = 32'h0000_0000;
    localparam logic [31:0] B1  = 32'h0000_0100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        cs_s   [2];
    logic        wr_s   [2];
    logic [3:0]  mask_s [2];
    logic [31:0] addr_s [2];
    logic [31:0] dwr_s  [2];
    logic [31:0] drd_s  [2];
    logic        rdy_s  [2];
    logic        err_s  [2];

    dmem_responder #(.DEPTH_WORDS(D0), .WAIT_STATES(WS0), .BASE_ADDR(B0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .cs(cs_s[0]), .wr(wr_s[0]), .mask(mask_s[0]),
        .addr(addr_s[0]), .data_wr(dwr_s[0]), .data_rd(drd_s[0]),
        .ready(rdy_s[0]), .err(err_s[0])
    );

    dmem_responder #(.DEPTH_WORDS(D1), .WAIT_STATES(WS1), .BASE_ADDR(B1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .cs(cs_s[1]), .wr(wr_s[1]), .mask(mask_s[1]),
        .addr(addr_s[1]), .data_wr(dwr_s[1]), .data_rd(drd_s[1]),
        .ready(rdy_s[1]), .err(err_s[1])
    );

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;

    int          ws_a  [2] = '{WS0, WS1};
    int          dep_a [2] = '{D0, D1};
    logic [31:0] base_a[2] = '{B0, B1};

    // Model state
    logic [31:0] mdl [int];
    int          rdy_cyc  [2] = '{-10, -10};
    bit          exp_err  [2] = '{1'b0, 1'b0};
    bit          exp_rd   [2] = '{1'b0, 1'b0};
    logic [31:0] exp_val  [2] = '{32'd0, 32'd0};
    logic [31:0] mdl_drd  [2] = '{32'd0, 32'd0};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                bit er;
                er = (cyc == rdy_cyc[k]);
                if (er && exp_rd[k]) mdl_drd[k] = exp_val[k];
                chk($sformatf("mon_ready%0d", k), 32'(rdy_s[k]), 32'(er));
                chk($sformatf("mon_err%0d", k), 32'(err_s[k]), 32'(er && exp_err[k]));
                chk($sformatf("mon_data_rd%0d", k), drd_s[k], mdl_drd[k]);
            end
        end
    end

    task automatic sync();
        @(negedge clk);
        #2;
    endtask

    task automatic idle(input int k);
        cs_s[k] = 1'b1;
    endtask

    // Present one request (cs may already be low for back-to-back) and wait
    // for its ready pulse. Called at negedge+2 with the DUT in IDLE.
    task automatic access(input int k, input bit w, input logic [3:0] m,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output bit e);
        logic [31:0] off;
        logic [31:0] t;
        bit          inr;
        int          key;
        int          c0;
        wr_s[k]   = w;
        mask_s[k] = m;
        addr_s[k] = a;
        dwr_s[k]  = d;
        cs_s[k]   = 1'b0;
        off = a - base_a[k];
        inr = (off < 32'(4 * dep_a[k]));
        key = k * 65536 + int'(off >> 2);
        c0  = cyc;
        rdy_cyc[k] = c0 + ws_a[k] + 2;
        exp_err[k] = !inr;
        exp_rd[k]  = w;
        if (w) begin
            exp_val[k] = inr ? mdl[key] : 32'd0;
        end else if (inr) begin
            t = mdl.exists(key) ? mdl[key] : 32'd0;
            for (int i = 0; i < 4; i++) if (m[i]) t[8*i +: 8] = d[8*i +: 8];
            mdl[key] = t;
        end
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            #2;
            if (rdy_s[k]) break;
        end
        chk($sformatf("latency%0d", k), 32'(cyc - c0), 32'(ws_a[k] + 2));
        rd = drd_s[k];
        e  = err_s[k];
    endtask

    logic [31:0] rd;
    bit          e;

    initial begin
        for (int k = 0; k < 2; k++) begin
            cs_s[k] = 1'b1; wr_s[k] = 1'b1; mask_s[k] = 4'h0;
            addr_s[k] = 32'd0; dwr_s[k] = 32'd0;
        end
        repeat (3) sync();
        for (int k = 0; k < 2; k++) begin
            chk("reset_ready", 32'(rdy_s[k]), 32'd0);
            chk("reset_err", 32'(err_s[k]), 32'd0);
            chk("reset_data_rd", drd_s[k], 32'd0);
        end
        rst_n = 1'b1;
        sync();

        // Reset in the middle of a write's wait state aborts it.
        access(0, 1'b0, 4'hF, 32'h10, 32'h1111_1111, rd, e);
        idle(0);
        sync();
        wr_s[0] = 1'b0; mask_s[0] = 4'hF; addr_s[0] = 32'h10;
        dwr_s[0] = 32'hDEAD_BEEF; cs_s[0] = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        cs_s[0] = 1'b1;
        @(negedge clk);
        chk("rst_mid_ready", 32'(rdy_s[0]), 32'd0);
        chk("rst_mid_err", 32'(err_s[0]), 32'd0);
        chk("rst_mid_data_rd", drd_s[0], 32'd0);
        rdy_cyc = '{-10, -10};
        mdl_drd = '{32'd0, 32'd0};
        sync();
        rst_n = 1'b1;
        sync();
        access(0, 1'b1, 4'h0, 32'h10, 32'd0, rd, e);
        chk("abort_rd", rd, 32'h1111_1111);
        idle(0); sync();

        // Full word write/read.
        access(0, 1'b0, 4'hF, 32'h40, 32'h1234_5678, rd, e);
        chk("wr40_err", 32'(e), 32'd0);
        idle(0); sync();
        access(0, 1'b1, 4'h0, 32'h40, 32'd0, rd, e);
        chk("rd40", rd, 32'h1234_5678);
        chk("rd40_err", 32'(e), 32'd0);
        idle(0); sync();

        // Byte masks.
        access(0, 1'b0, 4'hF, 32'h44, 32'hAABB_CCDD, rd, e);
        idle(0); sync();
        access(0, 1'b0, 4'b0010, 32'h44, 32'h0000_EE00, rd, e);
        idle(0); sync();
        access(0, 1'b1, 4'hF, 32'h44, 32'd0, rd, e);
        chk("mask0010", rd, 32'hAABB_EEDD);
        idle(0); sync();
        access(0, 1'b0, 4'b0000, 32'h44, 32'hFFFF_FFFF, rd, e);
        chk("mask0000_err", 32'(e), 32'd0);
        idle(0); sync();
        access(0, 1'b1, 4'h0, 32'h44, 32'd0, rd, e);
        chk("mask0000", rd, 32'hAABB_EEDD);
        idle(0); sync();

        // Out of range.
        access(0, 1'b0, 4'hF, 32'h0, 32'hCAFE_F00D, rd, e);
        idle(0); sync();
        access(0, 1'b0, 4'hF, 32'h1000, 32'h5555_5555, rd, e);
        chk("oor_wr_err", 32'(e), 32'd1);
        idle(0); sync();
        access(0, 1'b1, 4'h0, 32'h1000, 32'd0, rd, e);
        chk("oor_rd_data", rd, 32'd0);
        chk("oor_rd_err", 32'(e), 32'd1);
        idle(0); sync();
        access(0, 1'b1, 4'h0, 32'h0, 32'd0, rd, e);
        chk("word0_kept", rd, 32'hCAFE_F00D);
        idle(0); sync();

        // Back-to-back reads with cs held low.
        access(0, 1'b1, 4'h0, 32'h40, 32'd0, rd, e);
        chk("b2b_first", rd, 32'h1234_5678);
        access(0, 1'b1, 4'h0, 32'h44, 32'd0, rd, e);
        chk("b2b_second", rd, 32'hAABB_EEDD);
        idle(0); sync();

        // Zero wait states, nonzero base, ignored low address bits.
        access(1, 1'b0, 4'hF, 32'h140, 32'h5A5A_A5A5, rd, e);
        idle(1); sync();
        access(1, 1'b1, 4'h0, 32'h143, 32'd0, rd, e);
        chk("ws0_rd143", rd, 32'h5A5A_A5A5);
        idle(1); sync();
        access(1, 1'b1, 4'h0, 32'h0FC, 32'd0, rd, e);
        chk("below_base_err", 32'(e), 32'd1);
        chk("below_base_data", rd, 32'd0);
        idle(1); sync();
        access(1, 1'b1, 4'h0, 32'h200, 32'd0, rd, e);
        chk("above_top_err", 32'(e), 32'd1);
        idle(1); sync();

        // Randomized traffic over 16 known words per instance plus OOR hits.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 16; i++) begin
                access(k, 1'b0, 4'hF, base_a[k] + 32'(4 * i), $urandom, rd, e);
                idle(k); sync();
            end
            for (int n = 0; n < 200; n++) begin
                logic [31:0] a;
                bit          w;
                if ($urandom_range(0, 7) == 0)
                    a = base_a[k] + 32'(4 * dep_a[k]) + 32'($urandom_range(0, 255));
                else
                    a = base_a[k] + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
                w = $urandom_range(0, 1) == 1;
                access(k, w, 4'($urandom_range(0, 15)), a, $urandom, rd, e);
                if ($urandom_range(0, 1) == 1) begin
                    idle(k); sync();
                end
            end
            idle(k); sync();
        end

        repeat (3) sync();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Byte-masked data-memory slave that answers the load/store unit's memory requests. It accepts the `cs`/`wr`/`mask`/`addr`/`data_wr` request from the LSU and holds it in a small request/wait/response FSM. After a programmable number of wait states it commits masked writes or returns the full addressed word on `data_rd`. A one-cycle `ready` pulse tells the core that the access has completed.

## Interface
- `DEPTH_WORDS`, 1024: number of 32-bit words in the internal array; power of two.
- `WAIT_STATES`, 1: extra cycles inserted before the response; legal range 0..15.
- `BASE_ADDR`, 32'h0000_0000: byte address mapped to word 0; must be word-aligned.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `cs`  in  1  chip select, active-low; low = request pending.
- `wr`  in  1  0 = write (store), 1 = read (load).
- `mask`  in  4  byte-lane write enables; bit i enables `data_wr[8i+7:8i]`.
- `addr`  in  32  byte address; bits [1:0] are ignored.
- `data_wr`  in  32  lane-positioned store data.
- `data_rd`  out  32  read word, full 32 bits, lanes unextracted.
- `ready`  out  1  one-cycle completion pulse.
- `err`  out  1  out-of-range flag, valid only while `ready`=1.

## Operation
- FSM states are IDLE, WAIT and RESP.
- **IDLE:**
  - If `cs`=0 at an edge, capture `wr`, `mask`, `addr` and `data_wr` into request registers.
  - Load the counter with `WAIT_STATES`.
  - Go to WAIT, or directly to RESP when `WAIT_STATES`=0.
- **WAIT:**
  - Decrement the counter on each edge.
  - On the edge where the counter equals 1, go to RESP.
- **RESP:**
  - Lasts exactly one cycle and always returns to IDLE.
  - `cs` is not sampled in RESP.
- **Access commit:** the access is committed on the edge that enters RESP.
  - **Word index:** idx = (captured addr − `BASE_ADDR`) >> 2.
  - **In range:** in range means (addr − `BASE_ADDR`) < 4·`DEPTH_WORDS`, computed as unsigned 32-bit. Addresses below `BASE_ADDR` wrap to large values and are therefore out of range.
  - **Write, in range:** for each i with mask[i]=1, set array[idx] byte i = data_wr byte i. Other bytes are unchanged. mask=0000 completes normally with no change.
  - **Read, in range:** `data_rd` ← array[idx]. `mask` is ignored for reads.
  - **Out of range:** `err` is set with `ready`. A write is suppressed and a read drives `data_rd`=0.
- **`data_rd` hold:** `data_rd` holds its value until the next read response. Write responses do not change it.
- **Array:** the array is not reset. Read-before-write returns undefined contents.

## Timing
- **Reset:** `rst_n`=0 forces state=IDLE, counter=0, `ready`=0, `err`=0 and `data_rd`=0 immediately, asynchronously.
- **Abort:** reset during WAIT aborts the request, and no array write occurs. A write commits only on the edge entering RESP.
- **Latency:** let edge N be the edge that accepts a request. `ready` is high from edge N+`WAIT_STATES`+1 until the next edge.
  - WAIT_STATES=0: `ready` appears one cycle after acceptance.
  - WAIT_STATES=1: `ready` appears two cycles after acceptance.
- **`err`:** `err` is high only in the same cycle as `ready`, and is 0 otherwise.
- **Handshake:**
  - The initiator holds `cs`=0 and stable request fields until it sees `ready`=1.
  - Changes to the request fields after the accept edge are ignored, because the captured copy is used.
  - If `cs` is still 0 at the first IDLE edge after RESP, that edge accepts a new request (back-to-back).
  - Maximum throughput is one access per `WAIT_STATES`+2 cycles.
- **No overlap:** there is no pipelining and no outstanding-request queue. At most one request is in flight.

## Test plan
- **Reset values:** assert `rst_n`=0 mid-WAIT of a write (addr=0x10, data=0xDEADBEEF, mask=1111), then read 0x10 after a prior write of 0x11111111 → read returns 0x11111111. `ready`, `err` and `data_rd` are 0 during reset.
- **Full-word write/read, WAIT_STATES=1:** write 0x12345678 to 0x40 with mask 1111, then read 0x40.
  - `ready` is high exactly 2 cycles after each accept edge.
  - `data_rd`=0x12345678 and `err`=0.
- **Byte masks:**
  - Write 0xAABBCCDD to 0x44 with mask 1111.
  - Write 0x0000EE00 with mask 0010, then read → 0xAABBEEDD.
  - Write with mask 0000, then read → still 0xAABBEEDD.
- **Out of range, DEPTH_WORDS=1024:**
  - Write to 0x1000 → `ready`=1 with `err`=1.
  - Read 0x1000 → `data_rd`=0 and `err`=1.
  - Word 0 is unchanged.
- **Back-to-back:** hold `cs`=0 across two reads of 0x40 then 0x44 with the address switched right after `ready`. Each completes in WAIT_STATES+2 cycles, and `data_rd` matches each address in turn.
- **WAIT_STATES=0 and addr[1:0] ignored:** read 0x43 → `ready` one cycle after accept, and `data_rd` equals the word at 0x40.
